// File: rtl/mem_dump_scanner_pkg.sv
// Shared constants and FSM state type for the dirty-word memory dump scanner.
// Memory geometry must match the dirty-bit tracker feeding the scanner.
package mem_dump_scanner_pkg;

    localparam int N_ELEMENTS = 128;
    localparam int DATA_WIDTH = 32;
    localparam logic [7:0] TERMINATOR = 8'hFF;
    localparam int BYTES_PER_FRAME = DATA_WIDTH / 8 + 1;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        FETCH,
        SEND,
        WAIT_TX,
        NEXT,
        TERM,
        TERM_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mem_dump_scanner.sv
// Walks all data-memory addresses and streams {address, word MSB-first} for each
// dirty word over the UART, then a terminator byte.
module mem_dump_scanner
    import mem_dump_scanner_pkg::*;
#(
    parameter int         N_ELEMENTS = mem_dump_scanner_pkg::N_ELEMENTS,
    parameter int         ADDR_WIDTH = $clog2(N_ELEMENTS),
    parameter int         DATA_WIDTH = mem_dump_scanner_pkg::DATA_WIDTH,
    parameter logic [7:0] TERMINATOR = mem_dump_scanner_pkg::TERMINATOR
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic                  bit_sucio_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_start_o,
    input  logic                  tx_done_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int FRAME_BYTES = DATA_WIDTH / 8 + 1;
    localparam int IDX_W       = $clog2(FRAME_BYTES);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [IDX_W-1:0]      byte_idx_reg, byte_idx_next;
    logic [DATA_WIDTH-1:0] word_reg, word_next;
    logic [7:0]            tx_data_reg, tx_data_next;
    logic                  tx_start_reg, tx_start_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [7:0]            frame_byte;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        tx_data_next  = tx_data_reg;
        frame_byte    = '0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = CHECK;
                    addr_next  = '0;
                end
            end
            CHECK:   state_next = bit_sucio_i ? FETCH : NEXT;
            FETCH: begin
                word_next     = mem_data_i;
                byte_idx_next = '0;
                state_next    = SEND;
            end
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (tx_done_i) begin
                    if (byte_idx_reg == IDX_W'(FRAME_BYTES - 1)) begin
                        state_next = NEXT;
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                        state_next    = SEND;
                    end
                end
            end
            NEXT: begin
                if (addr_reg == ADDR_WIDTH'(N_ELEMENTS - 1)) begin
                    state_next = TERM;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = CHECK;
                end
            end
            TERM:      state_next = TERM_WAIT;
            TERM_WAIT: if (tx_done_i) state_next = DONE;
            DONE: begin
                addr_next  = '0;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase

        // Byte 0 of a frame is the address; the rest is the word, MSB first.
        case (byte_idx_next)
            IDX_W'(0): frame_byte[ADDR_WIDTH-1:0] = addr_reg;
            default:   frame_byte = word_next[DATA_WIDTH - 8 * int'(byte_idx_next) +: 8];
        endcase

        // Output registers load on entry so data and strobe share the SEND/TERM cycle.
        if (state_next == SEND) begin
            tx_data_next = frame_byte;
        end else if (state_next == TERM) begin
            tx_data_next = TERMINATOR;
        end

        tx_start_next = (state_next == SEND) || (state_next == TERM);
        done_next     = (state_next == DONE);
        busy_next     = (state_next != IDLE);
    end

    assign addr_o     = addr_reg;
    assign tx_data_o  = tx_data_reg;
    assign tx_start_o = tx_start_reg;
    assign busy_o     = busy_reg;
    assign done_o     = done_reg;

endmodule
